// File: rtl/alu_driver.sv
// Request/response sequencer around the 32-bit combinational ALU: decodes ALUOp/funct,
// registers operands into the ALU, captures its outputs. Optional macro: ALU_DRV_OVERLAP_EN.
module alu_driver #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_ILL = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             err_pend_q, err_pend_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_err_q, rsp_err_d;

    logic [2:0]       dec_op;
    logic             dec_err;

    always_comb begin
        dec_op  = OP_ILL;
        dec_err = 1'b1;
        case (req_aluop)
            2'b00: begin
                dec_op  = OP_ADD;
                dec_err = 1'b0;
            end
            2'b01: begin
                dec_op  = OP_SUB;
                dec_err = 1'b0;
            end
            2'b10: begin
                case (req_funct)
                    6'b100000: begin dec_op = OP_ADD; dec_err = 1'b0; end
                    6'b100010: begin dec_op = OP_SUB; dec_err = 1'b0; end
                    6'b100100: begin dec_op = OP_AND; dec_err = 1'b0; end
                    6'b100101: begin dec_op = OP_OR;  dec_err = 1'b0; end
                    6'b101010: begin dec_op = OP_SLT; dec_err = 1'b0; end
                    default: begin
                        dec_op  = OP_ILL;
                        dec_err = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_op  = OP_ILL;
                dec_err = 1'b1;
            end
        endcase
    end

    // req_ready is forced low while reset is asserted so nothing is accepted on that edge
    always_comb begin
        req_ready = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                req_ready = 1'b1;
            end
`ifdef ALU_DRV_OVERLAP_EN
            else if (state_q == RESP) begin
                req_ready = rsp_ready;
            end
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        err_pend_d   = err_pend_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_op_d   = dec_op;
                    alu_a_d    = req_a;
                    alu_b_d    = req_b;
                    err_pend_d = dec_err;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_carry_d  = ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) ? alu_carry : 1'b0;
                rsp_err_d    = err_pend_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
`ifdef ALU_DRV_OVERLAP_EN
                    if (req_valid) begin
                        alu_op_d   = dec_op;
                        alu_a_d    = req_a;
                        alu_b_d    = req_b;
                        err_pend_d = dec_err;
                        state_d    = EXEC;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            err_pend_q   <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            err_pend_q   <= err_pend_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;

endmodule
